// File: rtl/regfile_sb.sv
// LEGv8 register file with two combinational read ports, one synchronous write port,
// a hardwired zero register and a per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
    parameter int N    = 64,
    parameter int REGS = 32,
    parameter int A    = $clog2(REGS),
    parameter int ZR   = REGS - 1,
    parameter int FWD  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         w_signal,
    input  logic [A-1:0] w_addres,
    input  logic [N-1:0] w_input,
    input  logic [A-1:0] r1_addres,
    input  logic [A-1:0] r2_addres,
    output logic [N-1:0] r1_output,
    output logic [N-1:0] r2_output,
    input  logic         alloc_en,
    input  logic [A-1:0] alloc_addr,
    output logic         r1_busy,
    output logic         r2_busy,
    output logic [A:0]   busy_cnt
);

    localparam logic [A-1:0] ZR_ADDR = A'(ZR);
    localparam bit           FWD_EN  = (FWD != 0);

    logic [N-1:0]    regs_r [REGS];
    logic [REGS-1:0] busy_r;
    logic [REGS-1:0] busy_nxt_s;
    logic [A:0]      busy_cnt_r;
    logic [A:0]      cnt_nxt_s;
    logic            wr_en_s;
    logic            al_en_s;
    logic            cnt_inc_s;
    logic            cnt_dec_s;

    // Accesses aimed at the zero register are dropped here, so ZR never holds data or busy state
    assign wr_en_s = w_signal && (w_addres != ZR_ADDR);
    assign al_en_s = alloc_en && (alloc_addr != ZR_ADDR);

    // Data storage: reset loads each register with its own index, ZR slot stays constant zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) begin
                regs_r[i] <= (i == ZR) ? {N{1'b0}} : N'(i);
            end
        end else if (wr_en_s) begin
            regs_r[w_addres] <= w_input;
        end
    end

    // Next busy vector and count delta; an alloc overrides a same-cycle write clear
    always_comb begin
        busy_nxt_s = busy_r;
        cnt_nxt_s  = busy_cnt_r;
        if (wr_en_s) begin
            busy_nxt_s[w_addres] = 1'b0;
        end else begin
            busy_nxt_s[w_addres] = busy_r[w_addres];
        end
        if (al_en_s) begin
            busy_nxt_s[alloc_addr] = 1'b1;
        end else begin
            busy_nxt_s[alloc_addr] = busy_nxt_s[alloc_addr];
        end
        cnt_inc_s = al_en_s && !busy_r[alloc_addr];
        cnt_dec_s = wr_en_s && busy_r[w_addres] && !(al_en_s && (alloc_addr == w_addres));
        case ({cnt_inc_s, cnt_dec_s})
            2'b10:   cnt_nxt_s = busy_cnt_r + {{A{1'b0}}, 1'b1};
            2'b01:   cnt_nxt_s = busy_cnt_r - {{A{1'b0}}, 1'b1};
            default: cnt_nxt_s = busy_cnt_r;
        endcase
    end

    // Scoreboard state and its incrementally maintained population count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= {REGS{1'b0}};
            busy_cnt_r <= {(A+1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= cnt_nxt_s;
        end
    end

    assign busy_cnt = busy_cnt_r;

    // Read port 1 data and hazard flag, with optional bypass of the in-flight write
    always_comb begin
        r1_output = {N{1'b0}};
        r1_busy   = 1'b0;
        if (r1_addres == ZR_ADDR) begin
            r1_output = {N{1'b0}};
            r1_busy   = 1'b0;
        end else if (FWD_EN && wr_en_s && (w_addres == r1_addres)) begin
            r1_output = w_input;
            r1_busy   = (al_en_s && (alloc_addr == r1_addres)) ? busy_r[r1_addres] : 1'b0;
        end else begin
            r1_output = regs_r[r1_addres];
            r1_busy   = busy_r[r1_addres];
        end
    end

    // Read port 2 data and hazard flag, identical to port 1
    always_comb begin
        r2_output = {N{1'b0}};
        r2_busy   = 1'b0;
        if (r2_addres == ZR_ADDR) begin
            r2_output = {N{1'b0}};
            r2_busy   = 1'b0;
        end else if (FWD_EN && wr_en_s && (w_addres == r2_addres)) begin
            r2_output = w_input;
            r2_busy   = (al_en_s && (alloc_addr == r2_addres)) ? busy_r[r2_addres] : 1'b0;
        end else begin
            r2_output = regs_r[r2_addres];
            r2_busy   = busy_r[r2_addres];
        end
    end

endmodule
